// File: rtl/branch_resolve_if.sv
// branch_resolve_if: request, resolution and redirect signals of the branch
// resolution unit. The slave modport is the resolver itself; the master
// modport is the execute-stage / fetch side that drives it.
interface branch_resolve_if #(
    parameter int XLEN = 32
);
    // Resolve request from execute
    logic            in_valid;
    logic            in_ready;
    logic            in_is_branch;
    logic            in_is_jal;
    logic            in_is_jalr;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_alu_out;
    logic            in_zero;
    logic            in_lt;
    logic            in_ltu;
    logic            in_pred_taken;

    // Resolution results
    logic            resolved_valid;
    logic            resolved_taken;
    logic            misalign_err;

    // Redirect to fetch
    logic            flush;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output in_valid, in_is_branch, in_is_jal, in_is_jalr, in_funct3,
               in_pc, in_imm, in_alu_out, in_zero, in_lt, in_ltu,
               in_pred_taken, redirect_ready,
        input  in_ready, resolved_valid, resolved_taken, misalign_err,
               flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  in_valid, in_is_branch, in_is_jal, in_is_jalr, in_funct3,
               in_pc, in_imm, in_alu_out, in_zero, in_lt, in_ltu,
               in_pred_taken, redirect_ready,
        output in_ready, resolved_valid, resolved_taken, misalign_err,
               flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: resolves branch/JAL/JALR direction from ALU flags, compares
// against the front-end prediction and issues a held redirect plus a one-cycle
// flush on a mispredict. Optional statistics counters are built when the
// macro BRANCH_STATS_EN is defined; otherwise both counter outputs read 0.
module branch_resolve #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolve_if.slave  bus,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispredict_count
);

    typedef enum logic {
        S_IDLE,
        S_REDIRECT
    } state_t;

    state_t          r_state;
    logic            r_in_ready;
    logic            r_resolved_valid;
    logic            r_resolved_taken;
    logic            r_misalign_err;
    logic            r_flush;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_accept;
    logic            w_sel_jalr;
    logic            w_sel_jal;
    logic            w_sel_br;
    logic            w_br_legal;
    logic            w_cond;
    logic            w_decided;
    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_fall;
    logic [XLEN-1:0] w_next_pc;
    logic            w_misalign;
    logic            w_mispredict;

    // r_in_ready is only ever 1 in IDLE, so in_valid is ignored in REDIRECT
    assign w_accept = bus.in_valid && r_in_ready;

    // Classify the request and evaluate direction, target and mispredict
    always_comb begin
        w_sel_jalr = bus.in_is_jalr;
        w_sel_jal  = !bus.in_is_jalr && bus.in_is_jal;
        w_sel_br   = !bus.in_is_jalr && !bus.in_is_jal && bus.in_is_branch;
        w_br_legal = (bus.in_funct3 != 3'b010) && (bus.in_funct3 != 3'b011);

        w_cond = 1'b0;
        case (bus.in_funct3)
            3'b000:  w_cond = bus.in_zero;
            3'b001:  w_cond = !bus.in_zero;
            3'b100:  w_cond = bus.in_lt;
            3'b101:  w_cond = !bus.in_lt;
            3'b110:  w_cond = bus.in_ltu;
            3'b111:  w_cond = !bus.in_ltu;
            default: w_cond = 1'b0;
        endcase

        // Only legal control-flow instructions can ever mispredict
        w_decided = w_sel_jalr || w_sel_jal || (w_sel_br && w_br_legal);
        w_taken   = w_sel_jalr || w_sel_jal || (w_sel_br && w_br_legal && w_cond);

        w_target  = w_sel_jalr ? (bus.in_alu_out & ~XLEN'(1))
                               : (bus.in_pc + bus.in_imm);
        w_fall    = bus.in_pc + XLEN'(4);
        w_next_pc = w_taken ? w_target : w_fall;

        // A misaligned taken target raises an error instead of redirecting
        w_misalign   = w_taken && (w_target[1:0] != 2'b00);
        w_mispredict = w_decided && (w_taken != bus.in_pred_taken) && !w_misalign;
    end

    // Resolve FSM with registered pulses and held redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_in_ready       <= 1'b1;
            r_resolved_valid <= 1'b0;
            r_resolved_taken <= 1'b0;
            r_misalign_err   <= 1'b0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_resolved_valid <= 1'b0;
            r_resolved_taken <= 1'b0;
            r_misalign_err   <= 1'b0;
            r_flush          <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_resolved_valid <= 1'b1;
                        r_resolved_taken <= w_taken;
                        r_misalign_err   <= w_misalign;
                        if (w_mispredict) begin
                            r_state          <= S_REDIRECT;
                            r_in_ready       <= 1'b0;
                            r_flush          <= 1'b1;
                            r_redirect_valid <= 1'b1;
                            r_redirect_pc    <= w_next_pc;
                        end
                    end
                end
                S_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        r_state          <= S_IDLE;
                        r_in_ready       <= 1'b1;
                        r_redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= S_IDLE;
                    r_in_ready       <= 1'b1;
                    r_redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready       = r_in_ready;
    assign bus.resolved_valid = r_resolved_valid;
    assign bus.resolved_taken = r_resolved_taken;
    assign bus.misalign_err   = r_misalign_err;
    assign bus.flush          = r_flush;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_mp_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Saturating counts of legal conditional branches and redirect entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count <= '0;
            r_mp_count <= '0;
        end else begin
            if (w_accept && w_sel_br && w_br_legal)
                r_br_count <= sat_inc(r_br_count);
            if (w_accept && w_mispredict)
                r_mp_count <= sat_inc(r_mp_count);
        end
    end

    assign br_count         = r_br_count;
    assign mispredict_count = r_mp_count;
`else
    assign br_count         = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed vector table, hand-written redirect/reset
// sequences and a randomized run against an operand-level reference model.
module tb_branch_resolve;
    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_if #(.XLEN(XLEN)) bus ();
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispredict_count;

    branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .br_count         (br_count),
        .mispredict_count (mispredict_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] br_exp   = '0;
    logic [31:0] mp_exp   = '0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string tag);
`ifdef BRANCH_STATS_EN
        chk32({tag, ".br_count"}, br_count, br_exp);
        chk32({tag, ".mispredict_count"}, mispredict_count, mp_exp);
`else
        chk32({tag, ".br_count"}, br_count, 32'h0);
        chk32({tag, ".mispredict_count"}, mispredict_count, 32'h0);
`endif
    endtask

    task automatic drive(input logic br, input logic jal, input logic jalr,
                         input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] alu,
                         input logic z, input logic lt, input logic ltu,
                         input logic pred);
        bus.in_valid      = 1'b1;
        bus.in_is_branch  = br;
        bus.in_is_jal     = jal;
        bus.in_is_jalr    = jalr;
        bus.in_funct3     = f3;
        bus.in_pc         = pc;
        bus.in_imm        = imm;
        bus.in_alu_out    = alu;
        bus.in_zero       = z;
        bus.in_lt         = lt;
        bus.in_ltu        = ltu;
        bus.in_pred_taken = pred;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.in_valid       = 1'b0;
        bus.redirect_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        br, jal, jalr;
        logic [2:0]  f3;
        logic [31:0] pc, imm, alu;
        logic        z, lt, ltu, pred;
        logic        e_taken, e_mis, e_flush;
        logic [31:0] e_rpc;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic br, input logic jal,
                                input logic jalr, input logic [2:0] f3,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] alu, input logic z,
                                input logic lt, input logic ltu, input logic pred,
                                input logic et, input logic em, input logic ef,
                                input logic [31:0] erpc);
        vec_t v;
        v.name = nm; v.br = br; v.jal = jal; v.jalr = jalr; v.f3 = f3;
        v.pc = pc; v.imm = imm; v.alu = alu; v.z = z; v.lt = lt; v.ltu = ltu;
        v.pred = pred; v.e_taken = et; v.e_mis = em; v.e_flush = ef; v.e_rpc = erpc;
        return v;
    endfunction

    // Reference model: direction from source operands and instruction semantics
    typedef struct {
        logic        taken;
        logic        mis;
        logic        redirect;
        logic [31:0] npc;
        logic        is_cond_br;
    } ref_t;

    function automatic ref_t ref_model(input logic br, input logic jal, input logic jalr,
                                       input logic [2:0] f3, input logic [31:0] pc,
                                       input logic [31:0] imm, input logic [31:0] alu,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic pred);
        ref_t        r;
        logic        known;
        logic [31:0] target;
        r.taken = 1'b0; known = 1'b0; r.is_cond_br = 1'b0;
        target = pc + imm;
        if (jalr) begin
            known = 1'b1; r.taken = 1'b1; target = {alu[31:1], 1'b0};
        end else if (jal) begin
            known = 1'b1; r.taken = 1'b1;
        end else if (br) begin
            known = 1'b1; r.is_cond_br = 1'b1;
            case (f3)
                3'd0: r.taken = (a == b);
                3'd1: r.taken = (a != b);
                3'd4: r.taken = ($signed(a) <  $signed(b));
                3'd5: r.taken = ($signed(a) >= $signed(b));
                3'd6: r.taken = (a <  b);
                3'd7: r.taken = (a >= b);
                default: begin known = 1'b0; r.is_cond_br = 1'b0; end
            endcase
        end
        r.mis      = r.taken && (target % 4 != 0);
        r.redirect = known && (r.taken != pred) && !r.mis;
        r.npc      = r.taken ? target : pc + 32'd4;
        return r;
    endfunction

    vec_t tv[13];

    initial begin
        idle_inputs();
        tv[0]  = mk("beq_taken_mp",  1,0,0, 3'd0, 32'h100, 32'h20, 0, 1,0,0, 0, 1,0,1, 32'h120);
        tv[1]  = mk("bne_nt_ok",     1,0,0, 3'd1, 32'h100, 32'h20, 0, 1,0,0, 0, 0,0,0, 32'h0);
        tv[2]  = mk("bltu_nt_mp",    1,0,0, 3'd6, 32'h200, 32'h40, 0, 0,0,0, 1, 0,0,1, 32'h204);
        tv[3]  = mk("jalr_lsb",      0,0,1, 3'd0, 32'h80,  32'h0, 32'h1001, 0,0,0, 0, 1,0,1, 32'h1000);
        tv[4]  = mk("jal_misalign",  0,1,0, 3'd0, 32'h100, 32'h6, 0, 0,0,0, 0, 1,1,0, 32'h0);
        tv[5]  = mk("f3_010",        1,0,0, 3'd2, 32'h100, 32'h20, 0, 1,1,1, 1, 0,0,0, 32'h0);
        tv[6]  = mk("no_type",       0,0,0, 3'd0, 32'h100, 32'h20, 0, 1,1,1, 1, 0,0,0, 32'h0);
        tv[7]  = mk("bge_back_ok",   1,0,0, 3'd5, 32'h40, 32'hFFFFFFF8, 0, 0,0,0, 1, 1,0,0, 32'h0);
        tv[8]  = mk("jal_ok",        0,1,0, 3'd0, 32'h1000, 32'h100, 0, 0,0,0, 1, 1,0,0, 32'h0);
        tv[9]  = mk("prio_jalr",     1,1,1, 3'd1, 32'h10, 32'h100, 32'h3000, 1,0,0, 0, 1,0,1, 32'h3000);
        tv[10] = mk("blt_wrap",      1,0,0, 3'd4, 32'hFFFFFFFC, 32'h8, 0, 0,1,0, 0, 1,0,1, 32'h4);
        tv[11] = mk("beq_fall_wrap", 1,0,0, 3'd0, 32'hFFFFFFFC, 32'h10, 0, 0,0,0, 1, 0,0,1, 32'h0);
        tv[12] = mk("jalr_misalign", 0,0,1, 3'd0, 32'h0, 32'h0, 32'h1002, 0,0,0, 1, 1,1,0, 32'h0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk1("rst.in_ready", bus.in_ready, 1'b1);
        chk1("rst.resolved_valid", bus.resolved_valid, 1'b0);
        chk1("rst.resolved_taken", bus.resolved_taken, 1'b0);
        chk1("rst.misalign_err", bus.misalign_err, 1'b0);
        chk1("rst.flush", bus.flush, 1'b0);
        chk1("rst.redirect_valid", bus.redirect_valid, 1'b0);
        chk32("rst.redirect_pc", bus.redirect_pc, 32'h0);
        chk_counters("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            drive(tv[i].br, tv[i].jal, tv[i].jalr, tv[i].f3, tv[i].pc, tv[i].imm,
                  tv[i].alu, tv[i].z, tv[i].lt, tv[i].ltu, tv[i].pred);
            step();
            bus.in_valid = 1'b0;
            if (tv[i].br && !tv[i].jal && !tv[i].jalr && tv[i].f3 != 3'd2 && tv[i].f3 != 3'd3)
                br_exp++;
            if (tv[i].e_flush) mp_exp++;
            chk1({tv[i].name, ".resolved_valid"}, bus.resolved_valid, 1'b1);
            chk1({tv[i].name, ".resolved_taken"}, bus.resolved_taken, tv[i].e_taken);
            chk1({tv[i].name, ".misalign_err"}, bus.misalign_err, tv[i].e_mis);
            chk1({tv[i].name, ".flush"}, bus.flush, tv[i].e_flush);
            chk1({tv[i].name, ".redirect_valid"}, bus.redirect_valid, tv[i].e_flush);
            chk1({tv[i].name, ".in_ready"}, bus.in_ready, !tv[i].e_flush);
            if (tv[i].e_flush) begin
                chk32({tv[i].name, ".redirect_pc"}, bus.redirect_pc, tv[i].e_rpc);
                bus.redirect_ready = 1'b1;
                step();
                bus.redirect_ready = 1'b0;
                chk1({tv[i].name, ".rdy_back"}, bus.in_ready, 1'b1);
                chk1({tv[i].name, ".redirect_done"}, bus.redirect_valid, 1'b0);
                chk1({tv[i].name, ".flush_once"}, bus.flush, 1'b0);
            end
        end
        step();
        chk_counters("table");

        // Held redirect: ready low for 5 cycles, concurrent requests ignored
        drive(1,0,0, 3'd0, 32'h300, 32'h40, 0, 1,0,0, 0);
        step();
        br_exp++; mp_exp++;
        drive(0,1,0, 3'd0, 32'h500, 32'h10, 0, 0,0,0, 0);
        chk1("hold.flush0", bus.flush, 1'b1);
        chk32("hold.rpc0", bus.redirect_pc, 32'h340);
        for (int c = 1; c <= 5; c++) begin
            step();
            chk1($sformatf("hold.flush%0d", c), bus.flush, 1'b0);
            chk1($sformatf("hold.rv%0d", c), bus.redirect_valid, 1'b1);
            chk1($sformatf("hold.in_ready%0d", c), bus.in_ready, 1'b0);
            chk1($sformatf("hold.resolved%0d", c), bus.resolved_valid, 1'b0);
            chk32($sformatf("hold.rpc%0d", c), bus.redirect_pc, 32'h340);
        end
        bus.in_valid = 1'b0;
        bus.redirect_ready = 1'b1;
        step();
        bus.redirect_ready = 1'b0;
        chk1("hold.release_rv", bus.redirect_valid, 1'b0);
        chk1("hold.release_ready", bus.in_ready, 1'b1);
        chk1("hold.release_resolved", bus.resolved_valid, 1'b0);
        chk_counters("hold");

        // Asynchronous reset in the middle of a redirect
        drive(1,0,0, 3'd1, 32'h80, 32'h10, 0, 0,0,0, 0);
        step();
        bus.in_valid = 1'b0;
        chk1("arst.pre_rv", bus.redirect_valid, 1'b1);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        br_exp = '0; mp_exp = '0;
        chk1("arst.rv", bus.redirect_valid, 1'b0);
        chk1("arst.flush", bus.flush, 1'b0);
        chk32("arst.rpc", bus.redirect_pc, 32'h0);
        chk_counters("arst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk1("arst.in_ready", bus.in_ready, 1'b1);
        chk1("arst.rv_after", bus.redirect_valid, 1'b0);

        // Back-to-back branches, last one mispredicted
        drive(1,0,0, 3'd0, 32'h400, 32'h8, 0, 1,0,0, 1);
        step();
        chk1("b2b.rv1", bus.resolved_valid, 1'b1);
        chk1("b2b.rdy1", bus.in_ready, 1'b1);
        drive(1,0,0, 3'd1, 32'h404, 32'h8, 0, 1,0,0, 0);
        step();
        chk1("b2b.rv2", bus.resolved_valid, 1'b1);
        chk1("b2b.rt2", bus.resolved_taken, 1'b0);
        chk1("b2b.rdy2", bus.in_ready, 1'b1);
        drive(1,0,0, 3'd4, 32'h408, 32'h100, 0, 0,1,0, 0);
        step();
        bus.in_valid = 1'b0;
        br_exp += 3; mp_exp += 1;
        chk1("b2b.rv3", bus.resolved_valid, 1'b1);
        chk1("b2b.flush3", bus.flush, 1'b1);
        chk32("b2b.rpc3", bus.redirect_pc, 32'h508);
        bus.redirect_ready = 1'b1;
        step();
        bus.redirect_ready = 1'b0;
        chk_counters("b2b");

        // Randomized run against the reference model
        begin
            logic        m_pend;
            logic [31:0] m_rpc;
            m_pend = 1'b0;
            m_rpc  = '0;
            for (int n = 0; n < 400; n++) begin
                logic        v, rdy, br, jal, jalr, pred;
                logic        e_rv, e_rt, e_me, e_fl;
                logic [2:0]  f3;
                logic [31:0] a, b, pc, imm, alu;
                int          kind;
                ref_t        r;
                v    = ($urandom_range(0, 3) != 0);
                rdy  = $urandom_range(0, 1) == 1;
                kind = $urandom_range(0, 5);
                br   = (kind == 1 || kind == 5) || (kind == 4 && $urandom_range(0, 1) == 1);
                jal  = (kind == 2) || (kind == 4 && $urandom_range(0, 1) == 1);
                jalr = (kind == 3) || (kind == 4 && $urandom_range(0, 1) == 1);
                f3   = 3'($urandom_range(0, 7));
                a    = $urandom;
                b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
                pc   = $urandom & 32'hFFFFFFFC;
                imm  = $urandom;
                if ($urandom_range(0, 7) != 0) imm[1:0] = 2'b00;
                alu  = $urandom;
                if ($urandom_range(0, 7) != 0) alu[1] = 1'b0;
                pred = $urandom_range(0, 1) == 1;
                r = ref_model(br, jal, jalr, f3, pc, imm, alu, a, b, pred);

                drive(br, jal, jalr, f3, pc, imm, alu, (a == b),
                      ($signed(a) < $signed(b)), (a < b), pred);
                bus.in_valid       = v;
                bus.redirect_ready = rdy;

                e_rv = !m_pend && v;
                e_rt = e_rv && r.taken;
                e_me = e_rv && r.mis;
                e_fl = e_rv && r.redirect;
                if (e_rv && r.is_cond_br) br_exp++;
                if (e_fl) begin
                    mp_exp++;
                    m_rpc = r.npc;
                end
                m_pend = m_pend ? !rdy : e_fl;

                step();
                chk1($sformatf("rnd%0d.resolved_valid", n), bus.resolved_valid, e_rv);
                chk1($sformatf("rnd%0d.resolved_taken", n), bus.resolved_taken, e_rt);
                chk1($sformatf("rnd%0d.misalign_err", n), bus.misalign_err, e_me);
                chk1($sformatf("rnd%0d.flush", n), bus.flush, e_fl);
                chk1($sformatf("rnd%0d.redirect_valid", n), bus.redirect_valid, m_pend);
                chk1($sformatf("rnd%0d.in_ready", n), bus.in_ready, !m_pend);
                if (m_pend)
                    chk32($sformatf("rnd%0d.redirect_pc", n), bus.redirect_pc, m_rpc);
                chk_counters($sformatf("rnd%0d", n));
            end
        end

        idle_inputs();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
